// File: rtl/clint_bus_initiator_if.sv
// Request/response and device-strobe bundle between the LSU MMIO path and the CLINT timer port.
// Handshakes: a request transfers on a clock edge where req_valid_i & req_ready_o are both high;
// resp_valid_o is a one-cycle pulse with no backpressure; dev_ready_i answers one dev_cen_o pulse.
interface clint_bus_initiator_if;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_wen_i;
   logic [63:0] req_addr_i;
   logic [1:0]  req_size_i;
   logic        req_unsigned_i;
   logic [63:0] req_wdata_i;
   logic        resp_valid_o;
   logic [63:0] resp_rdata_o;
   logic        resp_err_o;
   logic        dev_cen_o;
   logic        dev_wen_o;
   logic [63:0] dev_addr_o;
   logic [63:0] dev_wdata_o;
   logic [63:0] dev_rdata_i;
   logic        dev_ready_i;

   modport master (
      input  req_valid_i, req_wen_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
      input  dev_rdata_i, dev_ready_i,
      output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
      output dev_cen_o, dev_wen_o, dev_addr_o, dev_wdata_o
   );

   modport slave (
      output req_valid_i, req_wen_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
      output dev_rdata_i, dev_ready_i,
      input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
      input  dev_cen_o, dev_wen_o, dev_addr_o, dev_wdata_o
   );
endinterface

// File: rtl/clint_bus_initiator.sv
// Single-outstanding CLINT initiator: address decode/alignment check, device strobes,
// read-modify-write for sub-doubleword stores, and one response pulse per accepted request.
module clint_bus_initiator #(
   parameter logic [63:0] ADDR_MTIME    = 64'h0000_0000_0200_BFF8,
   parameter logic [63:0] ADDR_MTIMECMP = 64'h0000_0000_0200_4000,
   parameter int unsigned TIMEOUT       = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   clint_bus_initiator_if.master        bus,
   output logic [2:0]                   o_dbg_state
);
   localparam int unsigned CW = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD_ISSUE = 3'd1,
      S_RD_WAIT  = 3'd2,
      S_WR_ISSUE = 3'd3,
      S_WR_WAIT  = 3'd4,
      S_RESP     = 3'd5
   } state_t;

   state_t          r_state, w_state_nx;
   logic [63:0]     r_addr, r_wdata, r_dev_wdata, r_rdata;
   logic [2:0]      r_off;
   logic [1:0]      r_size;
   logic            r_uns, r_wen, r_err;
   logic [CW-1:0]   r_cnt;

   logic            w_ready, w_accept, w_cen, w_wen, w_resp;
   logic            w_cnt_clr, w_cnt_inc, w_cap_load, w_cap_merge, w_tmo_fire, w_tmo;
   logic [63:0]     w_req_base, w_lane, w_load_data, w_size_mask, w_merged;
   logic [2:0]      w_align_mask;
   logic [5:0]      w_shift;
   logic            w_req_err;

   assign w_req_base = {bus.req_addr_i[63:3], 3'b000};

   always_comb begin
      case (bus.req_size_i)
         2'd0:    w_align_mask = 3'b000;
         2'd1:    w_align_mask = 3'b001;
         2'd2:    w_align_mask = 3'b011;
         default: w_align_mask = 3'b111;
      endcase
   end

   assign w_req_err = ((w_req_base != ADDR_MTIME) && (w_req_base != ADDR_MTIMECMP)) ||
                      ((bus.req_addr_i[2:0] & w_align_mask) != 3'b000);

   // Lane select and merge both work off the live device word during RD_WAIT.
   assign w_shift = {r_off, 3'b000};
   assign w_lane  = bus.dev_rdata_i >> w_shift;

   always_comb begin
      case (r_size)
         2'd0: begin
            w_size_mask = 64'h0000_0000_0000_00FF;
            w_load_data = {{56{~r_uns & w_lane[7]}}, w_lane[7:0]};
         end
         2'd1: begin
            w_size_mask = 64'h0000_0000_0000_FFFF;
            w_load_data = {{48{~r_uns & w_lane[15]}}, w_lane[15:0]};
         end
         2'd2: begin
            w_size_mask = 64'h0000_0000_FFFF_FFFF;
            w_load_data = {{32{~r_uns & w_lane[31]}}, w_lane[31:0]};
         end
         default: begin
            w_size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
            w_load_data = w_lane;
         end
      endcase
   end

   assign w_merged = (bus.dev_rdata_i & ~(w_size_mask << w_shift)) |
                     ((r_wdata & w_size_mask) << w_shift);
   assign w_tmo    = (r_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx  = r_state;
      w_ready     = 1'b0;
      w_accept    = 1'b0;
      w_cen       = 1'b0;
      w_wen       = 1'b0;
      w_resp      = 1'b0;
      w_cnt_clr   = 1'b0;
      w_cnt_inc   = 1'b0;
      w_cap_load  = 1'b0;
      w_cap_merge = 1'b0;
      w_tmo_fire  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ready = rst_n;
            if (bus.req_valid_i && rst_n) begin
               w_accept = 1'b1;
               if (w_req_err)                                  w_state_nx = S_RESP;
               else if (bus.req_wen_i && bus.req_size_i == 2'd3) w_state_nx = S_WR_ISSUE;
               else                                            w_state_nx = S_RD_ISSUE;
            end
         end
         S_RD_ISSUE: begin
            w_cen      = 1'b1;
            w_cnt_clr  = 1'b1;
            w_state_nx = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (bus.dev_ready_i) begin
               if (r_wen) begin
                  w_cap_merge = 1'b1;
                  w_state_nx  = S_WR_ISSUE;
               end else begin
                  w_cap_load = 1'b1;
                  w_state_nx = S_RESP;
               end
            end else if (w_tmo) begin
               w_tmo_fire = 1'b1;
               w_state_nx = S_RESP;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         S_WR_ISSUE: begin
            w_cen      = 1'b1;
            w_wen      = 1'b1;
            w_cnt_clr  = 1'b1;
            w_state_nx = S_WR_WAIT;
         end
         S_WR_WAIT: begin
            if (bus.dev_ready_i) begin
               w_state_nx = S_RESP;
            end else if (w_tmo) begin
               w_tmo_fire = 1'b1;
               w_state_nx = S_RESP;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         S_RESP: begin
            w_resp     = 1'b1;
            w_state_nx = S_IDLE;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_addr      <= '0;
         r_wdata     <= '0;
         r_dev_wdata <= '0;
         r_rdata     <= '0;
         r_off       <= '0;
         r_size      <= '0;
         r_uns       <= 1'b0;
         r_wen       <= 1'b0;
         r_err       <= 1'b0;
         r_cnt       <= '0;
      end else begin
         if (w_accept) begin
            r_addr      <= w_req_base;
            r_off       <= bus.req_addr_i[2:0];
            r_size      <= bus.req_size_i;
            r_uns       <= bus.req_unsigned_i;
            r_wen       <= bus.req_wen_i;
            r_wdata     <= bus.req_wdata_i;
            r_dev_wdata <= bus.req_wdata_i;
            r_rdata     <= '0;
            r_err       <= w_req_err;
         end
         if (w_cap_load)  r_rdata     <= w_load_data;
         if (w_cap_merge) r_dev_wdata <= w_merged;
         if (w_tmo_fire) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
         end
         if (w_cnt_clr)      r_cnt <= '0;
         else if (w_cnt_inc) r_cnt <= r_cnt + CW'(1);
      end
   end

   assign bus.req_ready_o  = w_ready;
   assign bus.resp_valid_o = w_resp;
   assign bus.resp_rdata_o = w_resp ? r_rdata : 64'h0;
   assign bus.resp_err_o   = w_resp & r_err;
   assign bus.dev_cen_o    = w_cen;
   assign bus.dev_wen_o    = w_wen;
   assign bus.dev_addr_o   = r_addr;
   assign bus.dev_wdata_o  = r_dev_wdata;
   assign o_dbg_state      = r_state;
endmodule
